// File: rtl/pre_emph_pkg.sv
// Shared defaults, mode encoding and rounding/saturation helpers for the pre-emphasis filter.
// Optional de-emphasis support is enabled by defining PRE_EMPH_DEEMPH_EN.
package pre_emph_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int COEF_W_DEF    = 16;
  localparam int COEF_FRAC_DEF = 15;
  localparam int NUM_CH_DEF    = 4;

  typedef enum logic {
    MODE_PRE = 1'b0,
    MODE_DE  = 1'b1
  } mode_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] round_k(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/pre_emph_mc_if.sv
// Sample stream, coefficient and history-clear bundle for pre_emph_mc.
// With PRE_EMPH_DEEMPH_EN defined the bundle also carries the per-sample mode bit.
interface pre_emph_mc_if
  import pre_emph_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [COEF_W-1:0]        coef;
  logic                     clr_hist;
  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_chan;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_chan;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;

`ifdef PRE_EMPH_DEEMPH_EN
  logic                     mode;

  modport slave (
    input  coef, clr_hist, in_valid, in_chan, in_data, out_ready, mode,
    output in_ready, out_valid, out_chan, out_data, out_sat
  );
  modport master (
    output coef, clr_hist, in_valid, in_chan, in_data, out_ready, mode,
    input  in_ready, out_valid, out_chan, out_data, out_sat
  );
`else
  modport slave (
    input  coef, clr_hist, in_valid, in_chan, in_data, out_ready,
    output in_ready, out_valid, out_chan, out_data, out_sat
  );
  modport master (
    output coef, clr_hist, in_valid, in_chan, in_data, out_ready,
    input  in_ready, out_valid, out_chan, out_data, out_sat
  );
`endif

endinterface

// File: rtl/pre_emph_rndsat.sv
// Combinational second stage: round the Q1.COEF_FRAC product, combine with x and clamp
// to the signed DATA_W range, flagging whenever the clamp engages.
module pre_emph_rndsat
  import pre_emph_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF
) (
  input  logic signed [DATA_W-1:0]        x,
  input  logic signed [DATA_W+COEF_W:0]   prod,
  input  logic                            add,
  output logic signed [DATA_W-1:0]        y,
  output logic                            sat
);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SW = DATA_W + 2;
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(DATA_W));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(DATA_W));

  function automatic logic signed [SW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = (p + PW'(round_k(COEF_FRAC))) >>> COEF_FRAC;
    return t[SW-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [SW-1:0] d);
    if (d > MAXV)      return MAXV[DATA_W-1:0];
    else if (d < MINV) return MINV[DATA_W-1:0];
    else               return d[DATA_W-1:0];
  endfunction

  logic signed [SW-1:0] r;
  logic signed [SW-1:0] xe;
  logic signed [SW-1:0] d;

  always_comb begin
    r   = round_shift(prod);
    xe  = SW'(x);
    d   = add ? (xe + r) : (xe - r);
    sat = (d > MAXV) || (d < MINV);
    y   = clamp(d);
  end

endmodule

// File: rtl/pre_emph_mc.sv
// Time-multiplexed multi-channel pre-emphasis y = x - a*x[n-1] with valid/ready stream.
// Define PRE_EMPH_DEEMPH_EN to add the mode input selecting de-emphasis y = x + a*y[n-1].
module pre_emph_mc
  import pre_emph_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int NUM_CH    = NUM_CH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pre_emph_mc_if.slave    bus
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam int PW   = DATA_W + COEF_W + 1;

  typedef logic signed [DATA_W-1:0] smp_t;

  smp_t                 hist_q [NUM_CH];
  smp_t                 hist_d [NUM_CH];

  logic                 vld_p1_q,  vld_p1_d;
  smp_t                 x_p1_q,    x_p1_d;
  logic [CH_W-1:0]      ch_p1_q,   ch_p1_d;
  logic signed [PW-1:0] prod_p1_q, prod_p1_d;
`ifdef PRE_EMPH_DEEMPH_EN
  mode_e                mode_p1_q, mode_p1_d;
  logic                 rng_p1_q,  rng_p1_d;
  mode_e                mode_in;
  logic                 busy;
`endif

  logic                 out_valid_q, out_valid_d;
  smp_t                 out_data_q,  out_data_d;
  logic [CH_W-1:0]      out_chan_q,  out_chan_d;
  logic                 out_sat_q,   out_sat_d;

  logic                 ce, in_ready, accept, in_rng;
  smp_t                 x_prev;
  logic signed [PW-1:0] prod;
  smp_t                 y_s2;
  logic                 sat_s2;

  // S1: history lookup, coefficient multiply and interlock
  always_comb begin
    ce     = !out_valid_q || bus.out_ready;
    in_rng = {1'b0, bus.in_chan} < (CH_W+1)'(NUM_CH);
    x_prev = in_rng ? hist_q[bus.in_chan] : '0;
    prod   = $signed(PW'({1'b0, bus.coef})) * PW'(x_prev);
`ifdef PRE_EMPH_DEEMPH_EN
    mode_in  = mode_e'(bus.mode);
    // A recursive sample must wait until its channel's previous output has landed in history.
    busy     = bus.in_valid && (mode_in == MODE_DE) &&
               ((vld_p1_q && (ch_p1_q == bus.in_chan)) ||
                (out_valid_q && (out_chan_q == bus.in_chan)));
    in_ready = ce && !busy;
`else
    in_ready = ce;
`endif
    accept = bus.in_valid && in_ready;
  end

  always_comb begin
    vld_p1_d  = vld_p1_q;
    x_p1_d    = x_p1_q;
    ch_p1_d   = ch_p1_q;
    prod_p1_d = prod_p1_q;
`ifdef PRE_EMPH_DEEMPH_EN
    mode_p1_d = mode_p1_q;
    rng_p1_d  = rng_p1_q;
`endif
    if (ce) vld_p1_d = accept;
    if (accept) begin
      x_p1_d    = bus.in_data;
      ch_p1_d   = bus.in_chan;
      prod_p1_d = prod;
`ifdef PRE_EMPH_DEEMPH_EN
      mode_p1_d = mode_in;
      rng_p1_d  = in_rng;
`endif
    end
  end

  // S2: round, combine, clamp into the output register
  pre_emph_rndsat #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_rndsat (
    .x    (x_p1_q),
    .prod (prod_p1_q),
`ifdef PRE_EMPH_DEEMPH_EN
    .add  (mode_p1_q == MODE_DE),
`else
    .add  (1'b0),
`endif
    .y    (y_s2),
    .sat  (sat_s2)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_sat_d   = out_sat_q;
    if (ce) begin
      out_valid_d = vld_p1_q;
      if (vld_p1_q) begin
        out_data_d = y_s2;
        out_chan_d = ch_p1_q;
        out_sat_d  = sat_s2;
      end
    end
  end

  // History: a newer S1 write overrides an older S2 write; clear overrides both.
  always_comb begin
    hist_d = hist_q;
`ifdef PRE_EMPH_DEEMPH_EN
    if (ce && vld_p1_q && (mode_p1_q == MODE_DE) && rng_p1_q)
      hist_d[ch_p1_q] = y_s2;
    if (accept && (mode_in == MODE_PRE) && in_rng)
      hist_d[bus.in_chan] = bus.in_data;
`else
    if (accept && in_rng)
      hist_d[bus.in_chan] = bus.in_data;
`endif
    if (bus.clr_hist) begin
      for (int i = 0; i < NUM_CH; i++) hist_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) hist_q[i] <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_sat_q   <= out_sat_d;
      hist_q      <= hist_d;
    end
  end

  always_ff @(posedge clk) begin
    x_p1_q    <= x_p1_d;
    ch_p1_q   <= ch_p1_d;
    prod_p1_q <= prod_p1_d;
`ifdef PRE_EMPH_DEEMPH_EN
    mode_p1_q <= mode_p1_d;
    rng_p1_q  <= rng_p1_d;
`endif
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_pre_emph_mc.sv
// Directed-vector bench for pre_emph_mc with a = 31785 (0.97 in Q1.15).
// A second instance with NUM_CH=3 exercises an out-of-range channel index.
module tb_pre_emph_mc;

  localparam int A = 31785;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pre_emph_mc_if #(.NUM_CH(4)) bus ();
  pre_emph_mc_if #(.NUM_CH(3)) bus2 ();

  pre_emph_mc #(.NUM_CH(4)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  pre_emph_mc #(.NUM_CH(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    int ch;
    int d;
    bit s;
  } rec_t;

  rec_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      q.push_back('{int'(bus.out_chan), int'(bus.out_data), bus.out_sat});
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input int d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'(ch);
    bus.in_data  = 16'(d);
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      nvec++;
      nerr++;
      $display("FAIL drive_timeout ch=%0d data=%0d in_ready stayed 0, required 1", ch, d);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 60) begin
      tick();
      k++;
    end
  endtask

  task automatic clr_pulse();
    bus.clr_hist = 1'b1;
    tick();
    bus.clr_hist = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.out_chan !== 2'd0 || bus.out_sat !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs got v=%b d=%0d ch=%0d s=%b, required all 0",
               bus.out_valid, bus.out_data, bus.out_chan, bus.out_sat);
    end
    rst = 1'b0;
    tick();
    nvec++;
    if (bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_latency();
    clr_pulse();
    q.delete();
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'd0;
    bus.in_data  = 16'sd1000;
    tick();
    bus.in_valid = 1'b0;
    nvec++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL lat_cycle1 out_valid got %b required 0", bus.out_valid);
    end
    tick();
    nvec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd1000) begin
      nerr++;
      $display("FAIL lat_cycle2 got v=%b d=%0d required v=1 d=1000", bus.out_valid, bus.out_data);
    end
    drive(0, 1000);
    wait_out(2);
    nvec++;
    if (q.size() !== 2 || q[1].d !== 30 || q[1].s !== 1'b0) begin
      nerr++;
      $display("FAIL lat_second got n=%0d d=%0d s=%b required n=2 d=30 s=0",
               q.size(), q.size() > 1 ? q[1].d : 0, q.size() > 1 ? q[1].s : 1'b0);
    end
  endtask

  task automatic test_saturation();
    clr_pulse();
    q.delete();
    drive(0, 32767);
    drive(0, -32768);
    wait_out(2);
    nvec++;
    if (q.size() !== 2) begin
      nerr++;
      $display("FAIL sat_count got %0d required 2", q.size());
    end else begin
      nvec++;
      if (q[0].d !== 32767 || q[0].s !== 1'b0) begin
        nerr++;
        $display("FAIL sat_first got d=%0d s=%b required d=32767 s=0", q[0].d, q[0].s);
      end
      nvec++;
      if (q[1].d !== -32768 || q[1].s !== 1'b1) begin
        nerr++;
        $display("FAIL sat_second got d=%0d s=%b required d=-32768 s=1", q[1].d, q[1].s);
      end
    end
  endtask

  task automatic test_interleave();
    int ec[6];
    int ed[6];
    ec = '{0, 1, 0, 1, 2, 2};
    ed = '{1000, 2000, 30, 60, -1000, -30};
    clr_pulse();
    q.delete();
    drive(0, 1000);
    drive(1, 2000);
    drive(0, 1000);
    drive(1, 2000);
    drive(2, -1000);
    drive(2, -1000);
    wait_out(6);
    nvec++;
    if (q.size() !== 6) begin
      nerr++;
      $display("FAIL ilv_count got %0d required 6", q.size());
    end
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      nvec++;
      if (q[i].ch !== ec[i] || q[i].d !== ed[i] || q[i].s !== 1'b0) begin
        nerr++;
        $display("FAIL ilv_out[%0d] got ch=%0d d=%0d s=%b required ch=%0d d=%0d s=0",
                 i, q[i].ch, q[i].d, q[i].s, ec[i], ed[i]);
      end
    end
  endtask

  task automatic test_coef_change();
    int ed[4];
    ed = '{1000, 30, 1000, -470};
    clr_pulse();
    q.delete();
    drive(0, 1000);
    drive(0, 1000);
    bus.coef = 16'd0;
    drive(0, 1000);
    bus.coef = 16'(A);
    drive(0, 500);
    wait_out(4);
    nvec++;
    if (q.size() !== 4) begin
      nerr++;
      $display("FAIL coef_count got %0d required 4", q.size());
    end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      nvec++;
      if (q[i].d !== ed[i]) begin
        nerr++;
        $display("FAIL coef_out[%0d] got %0d required %0d", i, q[i].d, ed[i]);
      end
    end
  endtask

  task automatic test_stall();
    int   ec[8];
    int   ed[8];
    rec_t held;
    ec = '{0, 1, 2, 3, 0, 1, 2, 3};
    ed = '{1000, 2000, -1000, 0, 30, 60, -30, 100};
    clr_pulse();
    q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) drive(ec[i], (i == 7) ? 100 : ed[i % 4]);
      end
      begin
        repeat (3) tick();
        bus.out_ready = 1'b0;
        held = '{int'(bus.out_chan), int'(bus.out_data), bus.out_sat};
        nvec++;
        if (bus.out_valid !== 1'b1) begin
          nerr++;
          $display("FAIL stall_valid got %b required 1", bus.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          nvec++;
          if (int'(bus.out_data) !== held.d || int'(bus.out_chan) !== held.ch ||
              bus.out_sat !== held.s || bus.out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL stall_hold[%0d] got ch=%0d d=%0d required ch=%0d d=%0d",
                     i, bus.out_chan, bus.out_data, held.ch, held.d);
          end
          nvec++;
          if (bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL stall_in_ready[%0d] got %b required 0", i, bus.in_ready);
          end
        end
        tick();
        bus.out_ready = 1'b1;
      end
    join
    wait_out(8);
    nvec++;
    if (q.size() !== 8) begin
      nerr++;
      $display("FAIL stall_count got %0d required 8", q.size());
    end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      nvec++;
      if (q[i].ch !== ec[i] || q[i].d !== ed[i]) begin
        nerr++;
        $display("FAIL stall_out[%0d] got ch=%0d d=%0d required ch=%0d d=%0d",
                 i, q[i].ch, q[i].d, ec[i], ed[i]);
      end
    end
  endtask

  task automatic test_clear();
    int ed[4];
    ed = '{1000, 1000, -470, 1000};
    clr_pulse();
    q.delete();
    drive(0, 1000);
    clr_pulse();
    drive(0, 1000);
    bus.clr_hist = 1'b1;
    drive(0, 500);
    bus.clr_hist = 1'b0;
    drive(0, 1000);
    wait_out(4);
    nvec++;
    if (q.size() !== 4) begin
      nerr++;
      $display("FAIL clr_count got %0d required 4", q.size());
    end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      nvec++;
      if (q[i].d !== ed[i]) begin
        nerr++;
        $display("FAIL clr_out[%0d] got %0d required %0d", i, q[i].d, ed[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    int ed[2];
    ed = '{1234, 500};
    for (int i = 0; i < 2; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_chan  = 2'd3;
      bus2.in_data  = 16'(ed[i]);
      tick();
      bus2.in_valid = 1'b0;
      tick();
      nvec++;
      if (bus2.out_valid !== 1'b1 || int'(bus2.out_data) !== ed[i] || bus2.out_chan !== 2'd3) begin
        nerr++;
        $display("FAIL oor_out[%0d] got v=%b ch=%0d d=%0d required v=1 ch=3 d=%0d",
                 i, bus2.out_valid, bus2.out_chan, bus2.out_data, ed[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    clr_pulse();
    q.delete();
    drive(0, 1000);
    wait_out(1);
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'd0;
    bus.in_data  = 16'sd1000;
    tick();
    bus.in_chan  = 2'd1;
    bus.in_data  = 16'sd2000;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_flush out_valid got %b required 0", bus.out_valid);
    end
    tick();
    nvec++;
    if (bus.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_no_inflight out_valid got %b required 0", bus.out_valid);
    end
    q.delete();
    drive(0, 1000);
    drive(1, 2000);
    wait_out(2);
    nvec++;
    if (q.size() !== 2 || q[0].d !== 1000 || q[1].d !== 2000) begin
      nerr++;
      $display("FAIL rst_hist got n=%0d d0=%0d d1=%0d required n=2 1000 2000",
               q.size(), q.size() > 0 ? q[0].d : 0, q.size() > 1 ? q[1].d : 0);
    end
  endtask

`ifdef PRE_EMPH_DEEMPH_EN
  task automatic test_deemph();
    int low;
    clr_pulse();
    q.delete();
    bus.mode     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'd0;
    bus.in_data  = 16'sd1000;
    tick();
    bus.in_data  = 16'sd0;
    low = 0;
    @(negedge clk);
    while (!bus.in_ready && low < 10) begin
      low++;
      @(negedge clk);
    end
    tick();
    bus.in_valid = 1'b0;
    wait_out(2);
    bus.mode = 1'b0;
    nvec++;
    if (low !== 2) begin
      nerr++;
      $display("FAIL de_interlock got %0d low cycles required 2", low);
    end
    nvec++;
    if (q.size() !== 2 || q[0].d !== 1000 || q[1].d !== 970) begin
      nerr++;
      $display("FAIL de_out got n=%0d d0=%0d d1=%0d required n=2 1000 970",
               q.size(), q.size() > 0 ? q[0].d : 0, q.size() > 1 ? q[1].d : 0);
    end
    clr_pulse();
  endtask
`endif

  initial begin
    bus.coef      = 16'(A);
    bus.clr_hist  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_chan   = 2'd0;
    bus.in_data   = 16'sd0;
    bus.out_ready = 1'b1;
    bus2.coef      = 16'(A);
    bus2.clr_hist  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_chan   = 2'd0;
    bus2.in_data   = 16'sd0;
    bus2.out_ready = 1'b1;
`ifdef PRE_EMPH_DEEMPH_EN
    bus.mode  = 1'b0;
    bus2.mode = 1'b0;
`endif
    #1;
    test_reset();
    test_latency();
    test_saturation();
    test_interleave();
    test_coef_change();
    test_stall();
    test_clear();
    test_out_of_range();
    test_midstream_reset();
`ifdef PRE_EMPH_DEEMPH_EN
    test_deemph();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
